// File: rtl/core_pkg.sv
// core_pkg: shared writeback select encodings, load funct3 codes and default datapath width
package core_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [2:0] {
    WB_ALU = 3'b000,
    WB_MEM = 3'b001,
    WB_PC4 = 3'b010,
    WB_CSR = 3'b011,
    WB_IMM = 3'b100
  } wb_sel_e;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: rotates raw word by byte offset (wrapping) then sign/zero-extends per funct3; in data/offset/funct3, out result
module load_formatter import core_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int OW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [OW-1:0]   offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);
  logic [OW+2:0]   sh;
  logic [XLEN-1:0] rot;
  always_comb begin
    sh = {offset, 3'b000};
    rot = (data >> sh) | (data << (XLEN - int'(sh)));
    result = funct3 == LB  ? XLEN'($signed(rot[7:0])) :
             funct3 == LH  ? XLEN'($signed(rot[15:0])) :
             funct3 == LW  ? XLEN'($signed(rot[31:0])) :
             funct3 == LBU ? XLEN'(rot[7:0]) :
             funct3 == LHU ? XLEN'(rot[15:0]) :
             (funct3 == LD && XLEN == 64) ? rot :
             (funct3 == LWU && XLEN == 64) ? XLEN'(rot[31:0]) : data;
  end
endmodule

// File: rtl/wb_stage_unit.sv
// wb_stage_unit: registered writeback stage; in_* from memory stage, mem_rsp_* load response, rf_* regfile write, load_busy/pulses to hazard logic
module wb_stage_unit import core_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int WB_SEL_W = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WB_SEL_W-1:0] in_wb_sel,
  input  logic [4:0]          in_rd,
  input  logic                in_rd_we,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_alu,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_csr,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_data,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                load_busy,
  output logic                unexpected_rsp,
  output logic                load_timeout,
  output logic                illegal_sel
);
  localparam int OW = $clog2(XLEN / 8);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);
  localparam logic IDLE = 1'b0;
  localparam logic WAIT_LOAD = 1'b1;
  logic            state;
  logic [CW-1:0]   cnt;
  logic [4:0]      l_rd;
  logic            l_we;
  logic [2:0]      l_f3;
  logic [OW-1:0]   l_off;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] sel_data;
  logic            is_load;
  logic            sel_bad;
  load_formatter #(.XLEN(XLEN), .OW(OW)) u_fmt (
    .data(mem_rsp_data),
    .offset(l_off),
    .funct3(l_f3),
    .result(ld_data)
  );
  always_comb begin
    in_ready = state == IDLE;
    load_busy = state == WAIT_LOAD;
    is_load = in_wb_sel == WB_SEL_W'(WB_MEM);
    sel_bad = in_wb_sel > WB_SEL_W'(WB_IMM);
    sel_data = in_wb_sel == WB_SEL_W'(WB_ALU) ? in_alu :
               in_wb_sel == WB_SEL_W'(WB_PC4) ? in_pc + XLEN'(4) :
               in_wb_sel == WB_SEL_W'(WB_CSR) ? in_csr :
               in_wb_sel == WB_SEL_W'(WB_IMM) ? in_imm : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      l_rd <= '0;
      l_we <= 1'b0;
      l_f3 <= '0;
      l_off <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      unexpected_rsp <= 1'b0;
      load_timeout <= 1'b0;
      illegal_sel <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      load_timeout <= 1'b0;
      illegal_sel <= 1'b0;
      unexpected_rsp <= mem_rsp_valid && state == IDLE;
      if (state == IDLE) begin
        if (in_valid && is_load) begin
          state <= WAIT_LOAD;
          cnt <= '0;
          l_rd <= in_rd;
          l_we <= in_rd_we;
          l_f3 <= in_funct3;
          l_off <= in_alu[OW-1:0];
        end else if (in_valid) begin
          rf_we <= in_rd_we && in_rd != 5'd0;
          rf_waddr <= in_rd;
          rf_wdata <= sel_data;
          illegal_sel <= sel_bad;
        end
      end else if (mem_rsp_valid) begin
        rf_we <= l_we && l_rd != 5'd0;
        rf_waddr <= l_rd;
        rf_wdata <= ld_data;
        state <= IDLE;
      end else if (cnt == TLAST) begin
        load_timeout <= 1'b1;
        state <= IDLE;
      end else
        cnt <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_wb_stage_unit.sv
// tb_wb_stage_unit: directed vectors with hand-computed expectations for wb_stage_unit
module tb_wb_stage_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_wb_sel = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rd_we = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_csr = '0;
  logic [31:0] in_imm = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_busy;
  logic        unexpected_rsp;
  logic        load_timeout;
  logic        illegal_sel;
  int n_vec = 0;
  int n_bad = 0;
  wb_stage_unit #(.XLEN(32), .WB_SEL_W(3), .TIMEOUT_CYC(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_wb_sel(in_wb_sel),
    .in_rd(in_rd),
    .in_rd_we(in_rd_we),
    .in_funct3(in_funct3),
    .in_alu(in_alu),
    .in_pc(in_pc),
    .in_csr(in_csr),
    .in_imm(in_imm),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .load_busy(load_busy),
    .unexpected_rsp(unexpected_rsp),
    .load_timeout(load_timeout),
    .illegal_sel(illegal_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu);
    in_valid = 1'b1;
    in_wb_sel = sel;
    in_rd = rd;
    in_rd_we = 1'b1;
    in_funct3 = f3;
    in_alu = alu;
  endtask
  task automatic load_rsp(input string tag, input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] data, input logic we, input logic [31:0] exp);
    issue(3'b001, rd, f3, alu);
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(load_busy), 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = data;
    step();
    mem_rsp_valid = 1'b0;
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    if (we) chk({tag, "_wdata"}, rf_wdata, exp);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    #12;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();
    issue(3'b000, 5'd5, 3'b000, 32'h1234);
    step();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    issue(3'b010, 5'd6, 3'b000, 32'h0);
    in_pc = 32'hFFFF_FFFC;
    step();
    chk("pc4_we", 32'(rf_we), 32'd1);
    chk("pc4_waddr", 32'(rf_waddr), 32'd6);
    chk("pc4_wrap", rf_wdata, 32'h0);
    in_valid = 1'b0;
    step();
    chk("idle_we", 32'(rf_we), 32'd0);
    issue(3'b001, 5'd7, 3'b000, 32'h1002);
    step();
    in_valid = 1'b0;
    chk("lb_ready0", 32'(in_ready), 32'd0);
    chk("lb_we0", 32'(rf_we), 32'd0);
    step();
    chk("lb_ready1", 32'(in_ready), 32'd0);
    chk("lb_busy1", 32'(load_busy), 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h0080_0000;
    issue(3'b000, 5'd9, 3'b000, 32'h55);
    step();
    mem_rsp_valid = 1'b0;
    chk("lb_we", 32'(rf_we), 32'd1);
    chk("lb_waddr", 32'(rf_waddr), 32'd7);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    step();
    in_valid = 1'b0;
    chk("held_waddr", 32'(rf_waddr), 32'd9);
    chk("held_wdata", rf_wdata, 32'h55);
    load_rsp("lbu", 5'd8, 3'b100, 32'h2002, 32'h0080_0000, 1'b1, 32'h0000_0080);
    load_rsp("lhu", 5'd10, 3'b101, 32'h2002, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF);
    load_rsp("lh_wrap", 5'd11, 3'b001, 32'h2003, 32'hAABB_CCDD, 1'b1, 32'hFFFF_DDAA);
    load_rsp("lw", 5'd12, 3'b010, 32'h2000, 32'h8765_4321, 1'b1, 32'h8765_4321);
    load_rsp("rd0", 5'd0, 3'b010, 32'h2000, 32'h1111_1111, 1'b0, 32'h0);
    issue(3'b001, 5'd13, 3'b010, 32'h3000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_early", 32'(load_timeout), 32'd0);
    end
    step();
    chk("to_pulse", 32'(load_timeout), 32'd1);
    chk("to_we", 32'(rf_we), 32'd0);
    chk("to_ready", 32'(in_ready), 32'd1);
    step();
    chk("to_clear", 32'(load_timeout), 32'd0);
    issue(3'b001, 5'd14, 3'b010, 32'h3000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hCAFE_F00D;
    step();
    mem_rsp_valid = 1'b0;
    chk("edge_noto", 32'(load_timeout), 32'd0);
    chk("edge_we", 32'(rf_we), 32'd1);
    chk("edge_wdata", rf_wdata, 32'hCAFE_F00D);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("stray_pulse", 32'(unexpected_rsp), 32'd1);
    chk("stray_we", 32'(rf_we), 32'd0);
    step();
    chk("stray_clear", 32'(unexpected_rsp), 32'd0);
    issue(3'b110, 5'd3, 3'b000, 32'h9999);
    step();
    in_valid = 1'b0;
    chk("ill_pulse", 32'(illegal_sel), 32'd1);
    chk("ill_we", 32'(rf_we), 32'd1);
    chk("ill_wdata", rf_wdata, 32'h0);
    step();
    chk("ill_clear", 32'(illegal_sel), 32'd0);
    issue(3'b001, 5'd15, 3'b010, 32'h4000);
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(load_busy), 32'd0);
    chk("mrst_waddr", 32'(rf_waddr), 32'd0);
    chk("mrst_wdata", rf_wdata, 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("post_unexp", 32'(unexpected_rsp), 32'd1);
    chk("post_we", 32'(rf_we), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
